// File: rtl/i2c_sym_tx.sv
// i2c_sym_tx: symbol-level I2C bus driver.
// Takes one command symbol per handshake (START, bit 1, bit 0, STOP) and drives
// the open-drain SCL/SDA output-enables through four quarter periods.
// Honours SCL clock stretching in the second quarter and samples SDA on data
// bits so the byte layer can read ACK and data.
module i2c_sym_tx #(
   parameter int QUARTER_DIV = 250,
   parameter int CNT_W       = 16
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [2:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic       busy,
   output logic       sym_done,
   output logic       rx_bit,
   output logic       rx_bit_valid,
   output logic       arb_lost,
   output logic       cmd_err
);

   typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3, ERR} state_t;

   localparam logic [2:0] SYM_START = 3'd1;
   localparam logic [2:0] SYM_ONE   = 3'd2;
   localparam logic [2:0] SYM_ZERO  = 3'd3;
   localparam logic [2:0] SYM_STOP  = 3'd4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER_DIV - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       sym_q, sym_d;
   logic             sclMeta_q, sclS_q, sdaMeta_q, sdaS_q;
   logic             sclOe_q, sclOe_d, sdaOe_q, sdaOe_d;
   logic             symDone_q, symDone_d;
   logic             rxBit_q, rxBit_d;
   logic             rxBitValid_q, rxBitValid_d;
   logic             arbLost_q, arbLost_d;
   logic             accept, validCode, quarterEnd, symIsBit;

   assign cmd_ready    = (state_q == IDLE) && enable;
   assign accept       = cmd_valid && cmd_ready;
   assign validCode    = (cmd_data >= SYM_START) && (cmd_data <= SYM_STOP);
   assign quarterEnd   = (cnt_q == CNT_LAST);
   assign symIsBit     = (sym_q == SYM_ONE) || (sym_q == SYM_ZERO);
   assign busy         = (state_q == Q0) || (state_q == Q1) || (state_q == Q2) || (state_q == Q3);
   assign cmd_err      = (state_q == ERR);
   assign scl_oe       = sclOe_q;
   assign sda_oe       = sdaOe_q;
   assign sym_done     = symDone_q;
   assign rx_bit       = rxBit_q;
   assign rx_bit_valid = rxBitValid_q;
   assign arb_lost     = arbLost_q;

   // Two-flop synchronisers for the asynchronous pad inputs; idle bus reads high
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         sclMeta_q <= 1'b1;
         sclS_q    <= 1'b1;
         sdaMeta_q <= 1'b1;
         sdaS_q    <= 1'b1;
      end else begin
         sclMeta_q <= scl_i;
         sclS_q    <= sclMeta_q;
         sdaMeta_q <= sda_i;
         sdaS_q    <= sdaMeta_q;
      end
   end

   // State, quarter counter, latched symbol and registered outputs
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sym_q        <= '0;
         sclOe_q      <= 1'b0;
         sdaOe_q      <= 1'b0;
         symDone_q    <= 1'b0;
         rxBit_q      <= 1'b0;
         rxBitValid_q <= 1'b0;
         arbLost_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sym_q        <= sym_d;
         sclOe_q      <= sclOe_d;
         sdaOe_q      <= sdaOe_d;
         symDone_q    <= symDone_d;
         rxBit_q      <= rxBit_d;
         rxBitValid_q <= rxBitValid_d;
         arbLost_q    <= arbLost_d;
      end
   end

   // Quarter sequencing; the second quarter only counts while SCL is really high
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sym_d   = sym_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sym_d   = cmd_data;
               cnt_d   = '0;
               state_d = validCode ? Q0 : ERR;
            end
         end
         Q0, Q2, Q3: begin
            if (quarterEnd) begin
               cnt_d = '0;
               case (state_q)
                  Q0:      state_d = Q1;
                  Q2:      state_d = Q3;
                  default: state_d = IDLE;
               endcase
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         Q1: begin
            if (!sclS_q) begin
               cnt_d = '0;
            end else if (quarterEnd) begin
               cnt_d   = '0;
               state_d = Q2;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line levels for the upcoming quarter, SDA sampling and status pulses
   always_comb begin
      sclOe_d      = sclOe_q;
      sdaOe_d      = sdaOe_q;
      rxBit_d      = rxBit_q;
      rxBitValid_d = 1'b0;
      arbLost_d    = 1'b0;
      symDone_d    = (state_q == Q3) && (state_d == IDLE);
      case (state_d)
         Q0: begin
            if (sym_d == SYM_START) begin
               sdaOe_d = 1'b0;
            end else if (sym_d == SYM_STOP) begin
               sclOe_d = 1'b1;
               sdaOe_d = 1'b1;
            end else begin
               sclOe_d = 1'b1;
               sdaOe_d = (sym_d == SYM_ZERO);
            end
         end
         Q1: sclOe_d = 1'b0;
         Q2: begin
            if (sym_d == SYM_START) sdaOe_d = 1'b1;
            else if (sym_d == SYM_STOP) sdaOe_d = 1'b0;
         end
         Q3: begin
            if (sym_d != SYM_STOP) sclOe_d = 1'b1;
         end
         default: ;
      endcase
      if ((state_q == Q2) && (cnt_q == '0) && symIsBit) begin
         rxBit_d      = sdaS_q;
         rxBitValid_d = 1'b1;
         arbLost_d    = (sym_q == SYM_ONE) && !sdaS_q;
      end
   end

endmodule

// File: tb/tb_i2c_sym_tx.sv
// Testbench for i2c_sym_tx: directed symbols, scoreboard queues for the
// status pulses, and a bus-level decoder that turns the SCL/SDA lines back
// into symbol codes.
module tb_i2c_sym_tx;

   localparam int QD = 4;

   typedef struct packed {
      logic bitVal;
      logic arb;
   } rxExp_t;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [2:0] cmd_data = 3'd0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       scl_i, sda_i;
   logic       scl_oe, sda_oe, busy, sym_done, rx_bit, rx_bit_valid, arb_lost, cmd_err;
   logic       sclExt = 1'b1;
   logic       sdaExt = 1'b1;

   int         nCompared = 0;
   int         nFailed = 0;

   rxExp_t     expRx[$];
   logic [1:0] expDone[$];
   logic [1:0] expErr[$];
   int         expTap[$];
   logic       modelScl = 1'b0;
   logic       modelSda = 1'b0;

   logic       tapOn = 1'b0;
   logic       prevScl = 1'b1, prevSda = 1'b1, tapPending = 1'b0, tapLatched = 1'b0;
   logic       sclLine;
   rxExp_t     rxE;
   logic [1:0] oeE;
   int         tapE;

   assign scl_i   = sclExt;
   assign sda_i   = ~sda_oe & sdaExt;
   assign sclLine = ~scl_oe & sclExt;

   i2c_sym_tx #(.QUARTER_DIV(QD), .CNT_W(8)) dut (
      .clock(clock), .rst_n(rst_n), .enable(enable),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
      .busy(busy), .sym_done(sym_done), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
      .arb_lost(arb_lost), .cmd_err(cmd_err)
   );

   always #5 clock = ~clock;

   // Every comparison goes through here so the counters stay consistent
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Issue one symbol and push the responses it should produce
   task automatic applyStimulus(input logic [2:0] code, input bit abandon);
      int budget = 500;
      while (!cmd_ready && budget > 0) begin
         @(posedge clock); #1;
         budget--;
      end
      if (!cmd_ready) begin
         checkOutput("cmd_ready timeout", {31'd0, cmd_ready}, 32'd1);
         return;
      end
      if (code == 3'd2 || code == 3'd3) begin
         rxE.bitVal = (code == 3'd2) & sdaExt;
         rxE.arb    = (code == 3'd2) & ~rxE.bitVal;
         expRx.push_back(rxE);
      end
      case (code)
         3'd1: begin modelScl = 1'b1; modelSda = 1'b1; end
         3'd2: begin modelScl = 1'b1; modelSda = 1'b0; end
         3'd3: begin modelScl = 1'b1; modelSda = 1'b1; end
         3'd4: begin modelScl = 1'b0; modelSda = 1'b0; end
         default: expErr.push_back({modelScl, modelSda});
      endcase
      if (code >= 3'd1 && code <= 3'd4 && !abandon) expDone.push_back({modelScl, modelSda});
      cmd_data  = code;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      cmd_data  = 3'd7;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 500) begin
         @(posedge clock); #1;
         n++;
      end
      if (busy) checkOutput("busy timeout", {31'd0, busy}, 32'd0);
   endtask

   // Scoreboard monitor: pops an expectation whenever the DUT pulses a status
   always @(negedge clock) begin
      if (rx_bit_valid) begin
         if (expRx.size() == 0) checkOutput("unexpected rx_bit_valid", {31'd0, rx_bit_valid}, 32'd0);
         else begin
            rxE = expRx.pop_front();
            checkOutput("rx_bit", {31'd0, rx_bit}, {31'd0, rxE.bitVal});
            checkOutput("arb_lost", {31'd0, arb_lost}, {31'd0, rxE.arb});
         end
      end else if (arb_lost) begin
         checkOutput("arb_lost without rx_bit_valid", {31'd0, arb_lost}, 32'd0);
      end
      if (sym_done) begin
         if (expDone.size() == 0) checkOutput("unexpected sym_done", {31'd0, sym_done}, 32'd0);
         else begin
            oeE = expDone.pop_front();
            checkOutput("oe at sym_done", {30'd0, scl_oe, sda_oe}, {30'd0, oeE});
         end
      end
      if (cmd_err) begin
         if (expErr.size() == 0) checkOutput("unexpected cmd_err", {31'd0, cmd_err}, 32'd0);
         else begin
            oeE = expErr.pop_front();
            checkOutput("oe at cmd_err", {30'd0, scl_oe, sda_oe}, {30'd0, oeE});
         end
      end
   end

   // Bus decoder: START/STOP on SDA edges while SCL high, data bits on SCL fall
   always @(negedge clock) begin
      tapE = 0;
      if (tapOn) begin
         if (prevScl && sclLine && prevSda && !sda_i) begin
            tapE = 1; tapPending = 1'b0;
         end else if (prevScl && sclLine && !prevSda && sda_i) begin
            tapE = 4; tapPending = 1'b0;
         end else if (!prevScl && sclLine) begin
            tapPending = 1'b1; tapLatched = sda_i;
         end else if (prevScl && !sclLine && tapPending) begin
            tapE = tapLatched ? 2 : 3; tapPending = 1'b0;
         end
      end else begin
         tapPending = 1'b0;
      end
      if (tapE != 0) begin
         if (expTap.size() == 0) checkOutput("unexpected tap code", tapE, 0);
         else checkOutput("tap code", tapE, expTap.pop_front());
      end
      prevScl = sclLine;
      prevSda = sda_i;
   end

   // Keeps the run bounded even if the DUT locks up
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence
   initial begin
      int lowCnt;
      int n;
      enable = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset scl_oe", {31'd0, scl_oe}, 32'd0);
      checkOutput("reset sda_oe", {31'd0, sda_oe}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset sym_done", {31'd0, sym_done}, 32'd0);
      checkOutput("reset rx_bit", {31'd0, rx_bit}, 32'd0);
      checkOutput("reset rx_bit_valid", {31'd0, rx_bit_valid}, 32'd0);
      checkOutput("reset cmd_err", {31'd0, cmd_err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clock); #1;
      checkOutput("idle cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // START from the idle bus: cycle T+1 is the first Q0 cycle
      applyStimulus(3'd1, 1'b0);
      checkOutput("start busy T+1", {31'd0, busy}, 32'd1);
      repeat (7) @(posedge clock);
      #1 checkOutput("start sda_oe T+8", {31'd0, sda_oe}, 32'd0);
      @(posedge clock); #1;
      checkOutput("start sda_oe T+9", {31'd0, sda_oe}, 32'd1);
      repeat (3) @(posedge clock);
      #1 checkOutput("start scl_oe T+12", {31'd0, scl_oe}, 32'd0);
      @(posedge clock); #1;
      checkOutput("start scl_oe T+13", {31'd0, scl_oe}, 32'd1);
      repeat (3) @(posedge clock);
      #1 checkOutput("start busy T+16", {31'd0, busy}, 32'd1);
      @(posedge clock); #1;
      checkOutput("start busy T+17", {31'd0, busy}, 32'd0);
      checkOutput("start sym_done T+17", {31'd0, sym_done}, 32'd1);

      // Bit 0 then bit 1 with a cooperative bus; SCL released for 8 cycles each
      for (int b = 0; b < 2; b++) begin
         applyStimulus(b == 0 ? 3'd3 : 3'd2, 1'b0);
         lowCnt = 0;
         for (int i = 0; i < 16; i++) begin
            if (!scl_oe) lowCnt++;
            @(posedge clock); #1;
         end
         checkOutput("scl released cycles per bit", lowCnt, 2 * QD);
      end

      // Bit 1 while another master holds SDA low
      sdaExt = 1'b0;
      applyStimulus(3'd2, 1'b0);
      waitIdle();
      sdaExt = 1'b1;

      // Clock stretch: SCL held low for 50 cycles from T+3
      applyStimulus(3'd3, 1'b0);
      repeat (2) @(posedge clock);
      #1 sclExt = 1'b0;
      repeat (25) @(posedge clock);
      #1;
      checkOutput("stretch scl_oe", {31'd0, scl_oe}, 32'd0);
      checkOutput("stretch sda_oe stable", {31'd0, sda_oe}, 32'd1);
      repeat (25) @(posedge clock);
      #1 sclExt = 1'b1;
      n = 0;
      while (!sym_done && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      checkOutput("stretch done cycle", 53 + n, 67);

      // Invalid code: one ERR cycle, lines untouched, then a STOP
      applyStimulus(3'd6, 1'b0);
      checkOutput("err cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("err cmd_err", {31'd0, cmd_err}, 32'd1);
      @(posedge clock); #1;
      checkOutput("err cmd_ready T+2", {31'd0, cmd_ready}, 32'd1);
      applyStimulus(3'd4, 1'b0);
      waitIdle();
      checkOutput("stop scl_oe", {31'd0, scl_oe}, 32'd0);
      checkOutput("stop sda_oe", {31'd0, sda_oe}, 32'd0);

      // enable dropped mid-symbol: symbol completes, nothing new accepted
      applyStimulus(3'd2, 1'b0);
      enable = 1'b0;
      waitIdle();
      cmd_valid = 1'b1;
      cmd_data  = 3'd1;
      repeat (5) @(posedge clock);
      #1 checkOutput("no accept while disabled", {31'd0, busy}, 32'd0);
      cmd_valid = 1'b0;
      enable    = 1'b1;

      // Reset during Q2 of a bit 0: symbol abandoned
      applyStimulus(3'd3, 1'b1);
      repeat (9) @(posedge clock);
      #1 rst_n = 1'b0;
      @(posedge clock); #1;
      checkOutput("mid reset scl_oe", {31'd0, scl_oe}, 32'd0);
      checkOutput("mid reset sda_oe", {31'd0, sda_oe}, 32'd0);
      checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      modelScl = 1'b0;
      modelSda = 1'b0;
      @(posedge clock); #1;
      checkOutput("post reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
      enable = 1'b0;
      #1 checkOutput("post reset cmd_ready disabled", {31'd0, cmd_ready}, 32'd0);
      enable = 1'b1;

      // Loopback through the bus decoder
      tapOn = 1'b1;
      expTap.push_back(1);
      expTap.push_back(2);
      expTap.push_back(3);
      expTap.push_back(2);
      expTap.push_back(4);
      applyStimulus(3'd1, 1'b0);
      applyStimulus(3'd2, 1'b0);
      applyStimulus(3'd3, 1'b0);
      applyStimulus(3'd2, 1'b0);
      applyStimulus(3'd4, 1'b0);
      waitIdle();
      repeat (5) @(posedge clock);
      #1 tapOn = 1'b0;

      checkOutput("rx expectations left", expRx.size(), 0);
      checkOutput("done expectations left", expDone.size(), 0);
      checkOutput("err expectations left", expErr.size(), 0);
      checkOutput("tap expectations left", expTap.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
